irq_ctrl: RTL

//  Interrupt controller sitting on the system bridge as a peripheral slave, between the

---
 rtl/irq_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : irq_ctrl
// Purpose : Fixed-priority interrupt controller: synchronises and latches
//           sources, then hands one at a time to the CPU via claim/EOI.
// Rev     : 1.0  initial release
// ============================================================================
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             sys_rstn,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic             RE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             irq_out,
  output logic [2:0]       cur_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_s1;
  logic [N_SRC-1:0] r_s2;
  logic [N_SRC-1:0] r_s3;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_w1c;
  logic [2:0]       r_cur_id;
  logic [2:0]       w_cur_nxt;
  logic [2:0]       w_win;
  logic             r_irq;
  logic             w_any;
  logic             w_claim;
  logic             w_eoi;
  logic [31:0]      w_dout;
  logic             w_unused_din;

  // Data bits above the implemented sources are deliberately dropped.
  assign w_unused_din = &{1'b0, Din[31:N_SRC]};

  assign w_edge  = r_s2 & ~r_s3;
  assign w_elig  = r_pend & r_mask;
  assign w_any   = |w_elig;
  assign w_w1c   = (WE && (Addr == 2'd0)) ? Din[N_SRC-1:0] : '0;
  assign w_claim = RE && (Addr == 2'd3) && (r_state == ST_ASSERT) && w_any;
  assign w_eoi   = WE && (Addr == 2'd3) && (r_state == ST_SERVICE);

  always_comb begin
    w_win = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
  end

  // Edge sources: a fresh edge beats a simultaneous W1C or claim clear.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_mode[i]) begin
        w_pend_nxt[i] = w_edge[i] |
                        (r_pend[i] & ~w_w1c[i] & ~(w_claim && (w_win == 3'(i))));
      end else begin
        w_pend_nxt[i] = r_s2[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!w_any) begin
          w_state_nxt = ST_IDLE;
        end else if (w_claim) begin
          w_state_nxt = ST_SERVICE;
          w_cur_nxt   = w_win;
        end
      end
      ST_SERVICE: begin
        if (w_eoi) begin
          w_state_nxt = ST_IDLE;
          w_cur_nxt   = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cur_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_s3     <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_mode   <= '0;
      r_state  <= ST_IDLE;
      r_cur_id <= 3'd0;
      r_irq    <= 1'b0;
    end else begin
      r_s1     <= irq_in;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_pend   <= w_pend_nxt;
      if (WE && (Addr == 2'd1)) r_mask <= Din[N_SRC-1:0];
      if (WE && (Addr == 2'd2)) r_mode <= Din[N_SRC-1:0];
      r_state  <= w_state_nxt;
      r_cur_id <= w_cur_nxt;
      r_irq    <= (w_state_nxt == ST_ASSERT);
    end
  end

  always_comb begin
    w_dout = 32'h0;
    case (Addr)
      2'd0: w_dout = 32'(r_pend);
      2'd1: w_dout = 32'(r_mask);
      2'd2: w_dout = 32'(r_mode);
      2'd3: if (w_any && (r_state == ST_ASSERT)) w_dout = {1'b1, 28'd0, w_win};
      default: w_dout = 32'h0;
    endcase
  end

  assign Dout    = w_dout;
  assign irq_out = r_irq;
  assign cur_id  = r_cur_id;

endmodule
`default_nettype wire
